// File: rtl/slot_pkg.sv
// Shared definitions for the slot table and its dispatcher.
//   - default field widths, so the table and the dispatcher agree on layout
//   - slot status codes
//   - dispatcher FSM state encoding
package slot_pkg;

  localparam int unsigned DEF_INDEX_WIDTH    = 3;
  localparam int unsigned DEF_SRC_ADDR_WIDTH = 32;
  localparam int unsigned DEF_SRC_SIZE_WIDTH = 26;
  localparam int unsigned DEF_DST_ADDR_WIDTH = 32;
  localparam int unsigned DEF_DST_SIZE_WIDTH = 26;
  localparam int unsigned DEF_STATUS_WIDTH   = 2;
  localparam int unsigned DEF_PROFILE_WIDTH  = 32;

  localparam logic [1:0] SLOT_EMPTY     = 2'd0;
  localparam logic [1:0] SLOT_WAITING   = 2'd1;
  localparam logic [1:0] SLOT_EXECUTING = 2'd2;
  localparam logic [1:0] SLOT_DONE      = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_EXEC      = 3'd2,
    ST_WRITEBACK = 3'd3,
    ST_NEXT      = 3'd4
  } disp_state_t;

endpackage

// File: rtl/dma_cmd_chan.sv
// One DMA command channel of the slot dispatcher (used once for MM2S, once
// for S2MM). Latches the command fields while the slot is fetched, raises
// valid during execution until the handshake, and remembers the completion
// pulse.
// Ports:
//   clk, rst_n           clock, async active-low reset
//   i_fetch              dispatcher is in FETCH: capture i_addr/i_size
//   i_arm                FETCH of a WAITING slot: clear accept/done flags
//   i_active             dispatcher is in EXEC
//   i_addr, i_size       table read data for this channel
//   i_ready, i_done      DMA command ready, one-cycle completion pulse
//   o_valid, o_addr, o_size  command to the DMA engine
//   o_finished           accepted and done, including events this cycle
module dma_cmd_chan #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned SIZE_WIDTH = 26
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_fetch,
  input  logic                  i_arm,
  input  logic                  i_active,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [SIZE_WIDTH-1:0] i_size,
  input  logic                  i_ready,
  input  logic                  i_done,
  output logic                  o_valid,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic [SIZE_WIDTH-1:0] o_size,
  output logic                  o_finished
);

  logic [ADDR_WIDTH-1:0] r_addr;
  logic [SIZE_WIDTH-1:0] r_size;
  logic                  r_accepted;
  logic                  r_done;
  logic                  w_accepted;
  logic                  w_done;

  assign o_valid    = i_active && !r_accepted;
  assign w_accepted = r_accepted || (o_valid && i_ready);
  assign w_done     = r_done || i_done;
  assign o_finished = w_accepted && w_done;
  assign o_addr     = r_addr;
  assign o_size     = r_size;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr     <= '0;
      r_size     <= '0;
      r_accepted <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      if (i_fetch) begin
        r_addr <= i_addr;
        r_size <= i_size;
      end
      // A zero-length transfer has nothing to issue: treat it as already
      // accepted and completed so valid never rises on this channel.
      if (i_arm) begin
        r_accepted <= (i_size == '0);
        r_done     <= (i_size == '0);
      end else if (i_active) begin
        r_accepted <= w_accepted;
        r_done     <= w_done;
      end
    end
  end

endmodule

// File: rtl/slot_dispatcher.sv
// Slot dispatcher: on start, walks every slot of the table in index order.
// WAITING slots are marked EXECUTING, a load and a store command are issued
// to the DMA engines, and once both complete the slot is written back DONE
// together with the number of EXEC cycles it took. Other slots are skipped.
// Ports:
//   clk, reset           clock, async active-low reset
//   start                begin a sweep (sampled in IDLE only)
//   busy, sweep_done     sweep in progress, one-cycle end-of-sweep pulse
//   rd_index, rd_*       table read select and combinational read data
//   wr_index, wr_status, set_status, wr_profile, set_profile  table writes
//   mm2s_cmd_*, s2mm_cmd_*  DMA command channels (valid/ready)
//   mm2s_done, s2mm_done one-cycle DMA completion pulses
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | waiting for start
// FETCH     | read slot idx, latch command fields, mark EXECUTING if WAITING
// EXEC      | commands outstanding; profile counter running
// WRITEBACK | write DONE and profile for slot idx
// NEXT      | advance idx, or finish the sweep after the last slot
module slot_dispatcher
  import slot_pkg::*;
#(
  parameter int unsigned INDEX_WIDTH    = DEF_INDEX_WIDTH,
  parameter int unsigned SRC_ADDR_WIDTH = DEF_SRC_ADDR_WIDTH,
  parameter int unsigned SRC_SIZE_WIDTH = DEF_SRC_SIZE_WIDTH,
  parameter int unsigned DST_ADDR_WIDTH = DEF_DST_ADDR_WIDTH,
  parameter int unsigned DST_SIZE_WIDTH = DEF_DST_SIZE_WIDTH,
  parameter int unsigned STATUS_WIDTH   = DEF_STATUS_WIDTH,
  parameter int unsigned PROFILE_WIDTH  = DEF_PROFILE_WIDTH
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  output logic                      busy,
  output logic                      sweep_done,
  output logic [INDEX_WIDTH-1:0]    rd_index,
  input  logic [SRC_ADDR_WIDTH-1:0] rd_src_addr,
  input  logic [SRC_SIZE_WIDTH-1:0] rd_src_size,
  input  logic [DST_ADDR_WIDTH-1:0] rd_des_addr,
  input  logic [DST_SIZE_WIDTH-1:0] rd_des_size,
  input  logic [STATUS_WIDTH-1:0]   rd_status,
  output logic [INDEX_WIDTH-1:0]    wr_index,
  output logic [STATUS_WIDTH-1:0]   wr_status,
  output logic                      set_status,
  output logic [PROFILE_WIDTH-1:0]  wr_profile,
  output logic                      set_profile,
  output logic                      mm2s_cmd_valid,
  input  logic                      mm2s_cmd_ready,
  output logic [SRC_ADDR_WIDTH-1:0] mm2s_cmd_addr,
  output logic [SRC_SIZE_WIDTH-1:0] mm2s_cmd_size,
  output logic                      s2mm_cmd_valid,
  input  logic                      s2mm_cmd_ready,
  output logic [DST_ADDR_WIDTH-1:0] s2mm_cmd_addr,
  output logic [DST_SIZE_WIDTH-1:0] s2mm_cmd_size,
  input  logic                      mm2s_done,
  input  logic                      s2mm_done
);

  localparam logic [STATUS_WIDTH-1:0] W_WAITING   = STATUS_WIDTH'(SLOT_WAITING);
  localparam logic [STATUS_WIDTH-1:0] W_EXECUTING = STATUS_WIDTH'(SLOT_EXECUTING);
  localparam logic [STATUS_WIDTH-1:0] W_DONE      = STATUS_WIDTH'(SLOT_DONE);

  disp_state_t              r_state;
  logic [INDEX_WIDTH-1:0]   r_idx;
  logic [PROFILE_WIDTH-1:0] r_prof;
  logic                     r_sweep_done;

  logic                     w_fetch;
  logic                     w_arm;
  logic                     w_exec;
  logic                     w_mm2s_fin;
  logic                     w_s2mm_fin;
  logic [PROFILE_WIDTH-1:0] w_prof_next;

  assign w_fetch = (r_state == ST_FETCH);
  assign w_arm   = w_fetch && (rd_status == W_WAITING);
  assign w_exec  = (r_state == ST_EXEC);

  // Profile counter sticks at all-ones rather than wrapping.
  assign w_prof_next = (r_prof == '1) ? r_prof : r_prof + PROFILE_WIDTH'(1);

  dma_cmd_chan #(
    .ADDR_WIDTH (SRC_ADDR_WIDTH),
    .SIZE_WIDTH (SRC_SIZE_WIDTH)
  ) u_mm2s (
    .clk        (clk),
    .rst_n      (reset),
    .i_fetch    (w_fetch),
    .i_arm      (w_arm),
    .i_active   (w_exec),
    .i_addr     (rd_src_addr),
    .i_size     (rd_src_size),
    .i_ready    (mm2s_cmd_ready),
    .i_done     (mm2s_done),
    .o_valid    (mm2s_cmd_valid),
    .o_addr     (mm2s_cmd_addr),
    .o_size     (mm2s_cmd_size),
    .o_finished (w_mm2s_fin)
  );

  dma_cmd_chan #(
    .ADDR_WIDTH (DST_ADDR_WIDTH),
    .SIZE_WIDTH (DST_SIZE_WIDTH)
  ) u_s2mm (
    .clk        (clk),
    .rst_n      (reset),
    .i_fetch    (w_fetch),
    .i_arm      (w_arm),
    .i_active   (w_exec),
    .i_addr     (rd_des_addr),
    .i_size     (rd_des_size),
    .i_ready    (s2mm_cmd_ready),
    .i_done     (s2mm_done),
    .o_valid    (s2mm_cmd_valid),
    .o_addr     (s2mm_cmd_addr),
    .o_size     (s2mm_cmd_size),
    .o_finished (w_s2mm_fin)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_idx        <= '0;
      r_prof       <= '0;
      r_sweep_done <= 1'b0;
    end else begin
      r_sweep_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_idx   <= '0;
            r_state <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (rd_status == W_WAITING) begin
            r_prof  <= '0;
            r_state <= ST_EXEC;
          end else begin
            r_state <= ST_NEXT;
          end
        end
        ST_EXEC: begin
          r_prof <= w_prof_next;
          if (w_mm2s_fin && w_s2mm_fin) begin
            r_state <= ST_WRITEBACK;
          end
        end
        ST_WRITEBACK: begin
          r_state <= ST_NEXT;
        end
        ST_NEXT: begin
          if (r_idx == '1) begin
            r_sweep_done <= 1'b1;
            r_state      <= ST_IDLE;
          end else begin
            r_idx   <= r_idx + INDEX_WIDTH'(1);
            r_state <= ST_FETCH;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Table strobes are decoded from the registered state so the table sees
  // them for a full cycle and captures at the following edge.
  always_comb begin
    busy        = (r_state != ST_IDLE);
    sweep_done  = r_sweep_done;
    rd_index    = r_idx;
    wr_index    = r_idx;
    wr_status   = '0;
    set_status  = 1'b0;
    wr_profile  = '0;
    set_profile = 1'b0;
    if (w_arm) begin
      set_status = 1'b1;
      wr_status  = W_EXECUTING;
    end else if (r_state == ST_WRITEBACK) begin
      set_status  = 1'b1;
      wr_status   = W_DONE;
      set_profile = 1'b1;
      wr_profile  = r_prof;
    end
  end

endmodule

// File: tb/tb_slot_dispatcher.sv
module tb_slot_dispatcher;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        busy, sweep_done;
  logic [2:0]  rd_index, wr_index;
  logic [31:0] rd_src_addr, rd_des_addr;
  logic [25:0] rd_src_size, rd_des_size;
  logic [1:0]  rd_status, wr_status;
  logic        set_status, set_profile;
  logic [31:0] wr_profile;
  logic        mm2s_cmd_valid, mm2s_cmd_ready, s2mm_cmd_valid, s2mm_cmd_ready;
  logic [31:0] mm2s_cmd_addr, s2mm_cmd_addr;
  logic [25:0] mm2s_cmd_size, s2mm_cmd_size;
  logic        mm2s_done, s2mm_done;

  always #5 clk = ~clk;

  slot_dispatcher dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .sweep_done(sweep_done),
    .rd_index(rd_index), .rd_src_addr(rd_src_addr), .rd_src_size(rd_src_size),
    .rd_des_addr(rd_des_addr), .rd_des_size(rd_des_size), .rd_status(rd_status),
    .wr_index(wr_index), .wr_status(wr_status), .set_status(set_status),
    .wr_profile(wr_profile), .set_profile(set_profile),
    .mm2s_cmd_valid(mm2s_cmd_valid), .mm2s_cmd_ready(mm2s_cmd_ready),
    .mm2s_cmd_addr(mm2s_cmd_addr), .mm2s_cmd_size(mm2s_cmd_size),
    .s2mm_cmd_valid(s2mm_cmd_valid), .s2mm_cmd_ready(s2mm_cmd_ready),
    .s2mm_cmd_addr(s2mm_cmd_addr), .s2mm_cmd_size(s2mm_cmd_size),
    .mm2s_done(mm2s_done), .s2mm_done(s2mm_done)
  );

  // Slot table model: combinational read, writes captured after the edge.
  logic [31:0] t_src_addr [8];
  logic [25:0] t_src_size [8];
  logic [31:0] t_dst_addr [8];
  logic [25:0] t_dst_size [8];
  logic [1:0]  t_status   [8];
  logic [31:0] t_prof     [8];

  assign rd_src_addr = t_src_addr[rd_index];
  assign rd_src_size = t_src_size[rd_index];
  assign rd_des_addr = t_dst_addr[rd_index];
  assign rd_des_size = t_dst_size[rd_index];
  assign rd_status   = t_status[rd_index];

  // DMA responder timing per slot: ready delay after valid rises, done delay
  // after the accept cycle (0 = done in the accept cycle).
  int m_rdly [8], m_ddly [8], s_rdly [8], s_ddly [8];

  // Expected table after a sweep.
  logic [1:0]  e_status [8];
  logic [31:0] e_prof   [8];

  int n_checks = 0;
  int n_errors = 0;

  int busy_cnt, done_cnt, done_k, set_st_cnt, m_acc, s_acc;
  int m_wcnt, m_dcnt, s_wcnt, s_dcnt;
  bit seen_exec [8];
  bit          pend_st_v, pend_pf_v;
  logic [2:0]  pend_st_idx, pend_pf_idx;
  logic [1:0]  pend_st_val;
  logic [31:0] pend_pf_val;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: cycles a WAITING slot spends in EXEC. A channel with data
  // finishes rdly+ddly cycles after EXEC entry; EXEC lasts until the later
  // channel finishes, and at least one cycle.
  function automatic int exec_cycles(input int i);
    int n;
    n = 1;
    if (t_src_size[i] != 0 && m_rdly[i] + m_ddly[i] + 1 > n) n = m_rdly[i] + m_ddly[i] + 1;
    if (t_dst_size[i] != 0 && s_rdly[i] + s_ddly[i] + 1 > n) n = s_rdly[i] + s_ddly[i] + 1;
    return n;
  endfunction

  task automatic reset_responders();
    m_wcnt = 0; m_dcnt = 0; s_wcnt = 0; s_dcnt = 0;
    mm2s_cmd_ready = 1'b0; s2mm_cmd_ready = 1'b0;
    mm2s_done = 1'b0; s2mm_done = 1'b0;
    pend_st_v = 1'b0; pend_pf_v = 1'b0;
    busy_cnt = 0; done_cnt = 0; done_k = 0; set_st_cnt = 0; m_acc = 0; s_acc = 0;
    for (int i = 0; i < 8; i++) seen_exec[i] = 1'b0;
  endtask

  // One clock cycle k of a sweep (k = 1 is the cycle after the start edge).
  // Entered #1 after the edge that begins cycle k.
  task automatic step(input int k, input bit poke);
    int  si;
    bit  rdy;
    if (pend_st_v) begin
      if (pend_st_val == 2'd3) check("done_after_executing", 64'(seen_exec[pend_st_idx]), 64'd1);
      if (pend_st_val == 2'd2) seen_exec[pend_st_idx] = 1'b1;
      t_status[pend_st_idx] = pend_st_val;
      pend_st_v = 1'b0;
    end
    if (pend_pf_v) begin
      t_prof[pend_pf_idx] = pend_pf_val;
      pend_pf_v = 1'b0;
    end
    if (poke) start = (k >= 3 && k <= 6);
    @(negedge clk);
    si = int'(rd_index);
    if (busy) busy_cnt++;
    if (sweep_done) begin
      done_cnt++;
      if (done_k == 0) done_k = k;
    end
    if (set_status) begin
      set_st_cnt++;
      pend_st_v = 1'b1; pend_st_idx = wr_index; pend_st_val = wr_status;
    end
    if (set_profile) begin
      pend_pf_v = 1'b1; pend_pf_idx = wr_index; pend_pf_val = wr_profile;
    end
    // load channel
    mm2s_done = 1'b0;
    if (m_dcnt > 0) begin
      m_dcnt--;
      if (m_dcnt == 0) mm2s_done = 1'b1;
    end
    rdy = 1'b0;
    if (mm2s_cmd_valid) begin
      check("mm2s_valid_nonzero_size", 64'(t_src_size[si] != 0), 64'd1);
      check("mm2s_addr", 64'(mm2s_cmd_addr), 64'(t_src_addr[si]));
      check("mm2s_size", 64'(mm2s_cmd_size), 64'(t_src_size[si]));
      rdy = (m_wcnt >= m_rdly[si]);
      m_wcnt++;
      if (rdy) begin
        m_acc++;
        m_wcnt = 0;
        if (m_ddly[si] == 0) mm2s_done = 1'b1; else m_dcnt = m_ddly[si];
      end
    end
    mm2s_cmd_ready = rdy;
    // store channel
    s2mm_done = 1'b0;
    if (s_dcnt > 0) begin
      s_dcnt--;
      if (s_dcnt == 0) s2mm_done = 1'b1;
    end
    rdy = 1'b0;
    if (s2mm_cmd_valid) begin
      check("s2mm_valid_nonzero_size", 64'(t_dst_size[si] != 0), 64'd1);
      check("s2mm_addr", 64'(s2mm_cmd_addr), 64'(t_dst_addr[si]));
      check("s2mm_size", 64'(s2mm_cmd_size), 64'(t_dst_size[si]));
      rdy = (s_wcnt >= s_rdly[si]);
      s_wcnt++;
      if (rdy) begin
        s_acc++;
        s_wcnt = 0;
        if (s_ddly[si] == 0) s2mm_done = 1'b1; else s_dcnt = s_ddly[si];
      end
    end
    s2mm_cmd_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic start_pulse();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic do_sweep(input string name, input bit poke);
    int total, nwait, nm, ns, n;
    total = 0; nwait = 0; nm = 0; ns = 0;
    for (int i = 0; i < 8; i++) begin
      if (t_status[i] == 2'd1) begin
        n = exec_cycles(i);
        total += 3 + n;
        nwait++;
        if (t_src_size[i] != 0) nm++;
        if (t_dst_size[i] != 0) ns++;
        e_status[i] = 2'd3;
        e_prof[i]   = 32'(n);
      end else begin
        total += 2;
        e_status[i] = t_status[i];
        e_prof[i]   = t_prof[i];
      end
    end
    reset_responders();
    start_pulse();
    for (int k = 1; k <= total + 4; k++) step(k, poke);
    start = 1'b0;
    $display("sweep %s: %0d slots waiting, expected length %0d", name, nwait, total);
    check({name, ":sweep_done_cycle"}, 64'(done_k), 64'(total + 1));
    check({name, ":sweep_done_count"}, 64'(done_cnt), 64'd1);
    check({name, ":busy_cycles"}, 64'(busy_cnt), 64'(total));
    check({name, ":set_status_count"}, 64'(set_st_cnt), 64'(2 * nwait));
    check({name, ":mm2s_accepts"}, 64'(m_acc), 64'(nm));
    check({name, ":s2mm_accepts"}, 64'(s_acc), 64'(ns));
    for (int i = 0; i < 8; i++) begin
      check($sformatf("%s:status[%0d]", name, i), 64'(t_status[i]), 64'(e_status[i]));
      check($sformatf("%s:profile[%0d]", name, i), 64'(t_prof[i]), 64'(e_prof[i]));
    end
  endtask

  task automatic clear_table();
    for (int i = 0; i < 8; i++) begin
      t_src_addr[i] = 32'h0; t_src_size[i] = 26'h0;
      t_dst_addr[i] = 32'h0; t_dst_size[i] = 26'h0;
      t_status[i] = 2'd0; t_prof[i] = 32'h0;
      m_rdly[i] = 0; m_ddly[i] = 0; s_rdly[i] = 0; s_ddly[i] = 0;
    end
  endtask

  task automatic random_table();
    for (int i = 0; i < 8; i++) begin
      t_src_addr[i] = $urandom; t_dst_addr[i] = $urandom;
      t_src_size[i] = ($urandom_range(0, 3) == 0) ? 26'h0 : 26'($urandom);
      t_dst_size[i] = ($urandom_range(0, 3) == 0) ? 26'h0 : 26'($urandom);
      t_status[i] = 2'($urandom_range(0, 3));
      t_prof[i] = $urandom;
      m_rdly[i] = $urandom_range(0, 4); m_ddly[i] = $urandom_range(0, 4);
      s_rdly[i] = $urandom_range(0, 4); s_ddly[i] = $urandom_range(0, 4);
    end
  endtask

  task automatic check_outputs_zero(input string name);
    check({name, ":busy"}, 64'(busy), 64'd0);
    check({name, ":sweep_done"}, 64'(sweep_done), 64'd0);
    check({name, ":mm2s_valid"}, 64'(mm2s_cmd_valid), 64'd0);
    check({name, ":s2mm_valid"}, 64'(s2mm_cmd_valid), 64'd0);
    check({name, ":set_status"}, 64'(set_status), 64'd0);
    check({name, ":set_profile"}, 64'(set_profile), 64'd0);
    check({name, ":rd_index"}, 64'(rd_index), 64'd0);
    check({name, ":mm2s_addr"}, 64'(mm2s_cmd_addr), 64'd0);
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    reset_responders();
    clear_table();
    #3;
    check_outputs_zero("reset");
    @(negedge clk);
    reset = 1'b1;

    // empty table
    do_sweep("empty", 1'b0);

    // slot 2 waiting, both dones three cycles after EXEC entry
    clear_table();
    t_status[2] = 2'd1;
    t_src_addr[2] = 32'h1000; t_src_size[2] = 26'd64;
    t_dst_addr[2] = 32'h2000; t_dst_size[2] = 26'd64;
    m_ddly[2] = 3; s_ddly[2] = 3;
    do_sweep("slot2", 1'b0);
    check("slot2:profile_is_4", 64'(t_prof[2]), 64'd4);

    // load ready held low 5 cycles, store accepted immediately
    clear_table();
    t_status[3] = 2'd1;
    t_src_addr[3] = 32'hA000_0040; t_src_size[3] = 26'd128;
    t_dst_addr[3] = 32'hB000_0080; t_dst_size[3] = 26'd32;
    m_rdly[3] = 5; s_ddly[3] = 1;
    do_sweep("backpressure", 1'b0);
    check("backpressure:profile_is_6", 64'(t_prof[3]), 64'd6);

    // zero-size transfers on slot 0
    clear_table();
    t_status[0] = 2'd1;
    t_src_addr[0] = 32'h1234; t_dst_addr[0] = 32'h5678;
    do_sweep("zero_size", 1'b0);
    check("zero_size:profile_is_1", 64'(t_prof[0]), 64'd1);

    // random table, start re-asserted while busy
    random_table();
    do_sweep("rand_poke", 1'b1);

    // reset during EXEC
    clear_table();
    t_status[1] = 2'd1;
    t_src_addr[1] = 32'hCAFE_0000; t_src_size[1] = 26'd16;
    t_dst_addr[1] = 32'hBEEF_0000; t_dst_size[1] = 26'd16;
    m_rdly[1] = 20; s_rdly[1] = 20;
    reset_responders();
    start_pulse();
    for (int k = 1; k <= 6; k++) step(k, 1'b0);
    check("rst:in_exec_valid", 64'(mm2s_cmd_valid), 64'd1);
    #2;
    reset = 1'b0;
    #1;
    check_outputs_zero("rst_mid");
    check("rst:slot1_executing", 64'(t_status[1]), 64'd2);
    @(negedge clk);
    mm2s_cmd_ready = 1'b0; s2mm_cmd_ready = 1'b0;
    mm2s_done = 1'b0; s2mm_done = 1'b0;
    reset = 1'b1;
    do_sweep("after_reset", 1'b0);

    // more random sweeps
    for (int r = 0; r < 4; r++) begin
      random_table();
      do_sweep($sformatf("rand%0d", r), 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/slot_dispatcher.md
# slot_dispatcher

Sequencer on the read side of the slot table. On a start pulse it walks every slot index in order. For each slot marked WAITING it:
- issues a load (MM2S) command and a store (S2MM) command to the DMA engines,
- waits for both completions,
- writes the slot back as DONE with its execution cycle count.

It drives the table's read index and the table's status/profile write strobes.

## Interface
- INDEX_WIDTH, 3, slot index width; 2^INDEX_WIDTH slots
- SRC_ADDR_WIDTH, 32, load address width
- SRC_SIZE_WIDTH, 26, load byte-count width
- DST_ADDR_WIDTH, 32, store address width
- DST_SIZE_WIDTH, 26, store byte-count width
- STATUS_WIDTH, 2, slot status width
- PROFILE_WIDTH, 32, profile counter width

Ports:
- clk  in  1  clock; one clock domain, all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  level sampled in IDLE; begins a sweep; ignored while busy
- busy  out  1  high whenever FSM not IDLE
- sweep_done  out  1  one-cycle pulse on return to IDLE
- rd_index  out  INDEX_WIDTH  slot select to table read mux
- rd_src_addr / rd_src_size / rd_des_addr / rd_des_size / rd_status  in  field widths  table read data, combinational from rd_index
- wr_index  out  INDEX_WIDTH  slot targeted by write strobes
- wr_status  out  STATUS_WIDTH; set_status  out  1  status write
- wr_profile  out  PROFILE_WIDTH; set_profile  out  1  profile write
- mm2s_cmd_valid  out  1; mm2s_cmd_ready  in  1; mm2s_cmd_addr  out  SRC_ADDR_WIDTH; mm2s_cmd_size  out  SRC_SIZE_WIDTH
- s2mm_cmd_valid  out  1; s2mm_cmd_ready  in  1; s2mm_cmd_addr  out  DST_ADDR_WIDTH; s2mm_cmd_size  out  DST_SIZE_WIDTH
- mm2s_done, s2mm_done  in  1  one-cycle completion pulses from DMA

## Operation
- Status encoding:
  - 0 EMPTY
  - 1 WAITING
  - 2 EXECUTING
  - 3 DONE
- Only WAITING slots are executed; all other slots are skipped untouched.
- FSM states: IDLE, FETCH, EXEC, WRITEBACK, NEXT.
- IDLE -> FETCH on start; idx := 0.
- FETCH:
  - rd_index = idx; latch addr/size fields into command registers.
  - If rd_status == WAITING: set_status = 1, wr_status = EXECUTING, wr_index = idx; go to EXEC; clear profile counter and load/store done flags.
  - Otherwise go to NEXT.
- EXEC:
  - Each command valid is high from EXEC entry until its own valid&&ready handshake. The two channels are independent.
  - Size 0 on a channel: its valid is never raised, and that channel counts as accepted and done.
  - done pulses are sticky and recorded on any EXEC cycle, including the accept cycle.
  - Exit to WRITEBACK in the cycle where both channels are accepted and both are done, counting events arriving that cycle.
  - Profile counter increments every EXEC cycle, saturating at all-ones.
- WRITEBACK: set_status = 1 with wr_status = DONE; set_profile = 1 with wr_profile = counter; wr_index = idx; go to NEXT.
- NEXT: if idx == 2^INDEX_WIDTH−1 go to IDLE and pulse sweep_done; else idx += 1 (INDEX_WIDTH-bit) and go to FETCH.
- Command addr/size outputs hold the latched values throughout EXEC and are stable while valid is high.
- Reset values:
  - state IDLE, idx 0
  - all valids, set_* strobes, busy, sweep_done at 0
  - counters and latched fields at 0
- Reset mid-operation: in-flight DMA commands are abandoned and the slot stays EXECUTING in the table; software must rewrite it.

## Timing
- rd_index, wr_*, set_*, and cmd valids are decoded from registered state; the table captures writes at the next edge.
- start sampled at edge t: FETCH at t+1.
- Skipped slot costs 2 cycles (FETCH, NEXT).
- Executed slot costs FETCH + N EXEC + WRITEBACK + NEXT, where N ≥ 1.
- Empty table, 8 slots: busy high for cycles t+1..t+16; sweep_done and busy low at t+17.
- Ready held high and done arriving on the accept cycle gives N = 1 and profile 1.

## Structure
- Shared package slot_pkg holds:
  - status constants EMPTY/WAITING/EXECUTING/DONE
  - FSM state enum
  - default width constants, shared with the slot table
- Sub-module dma_cmd_chan (one instance per direction) holds the valid/accepted/done-sticky logic and outputs chan_finished.
- Target size: roughly 200 lines RTL total.

## Test plan
- All slots EMPTY, start pulse -> no set_status or cmd valid; sweep_done exactly 17 cycles after start; busy high 16 cycles.
- Slot 2 WAITING (src 0x1000/64, dst 0x2000/64), ready tied high, both dones 3 cycles after EXEC entry -> slot 2 EXECUTING then DONE, profile 4; other slots untouched.
- mm2s_cmd_ready held low 5 cycles -> mm2s_cmd_valid and addr stable for 5 cycles; s2mm accepted independently at the first EXEC cycle.
- Slot 0 WAITING with src_size 0 and dst_size 0 -> no cmd valid; WRITEBACK after 1 EXEC cycle; profile 1.
- start asserted during a sweep -> ignored; only one sweep_done.
- reset deasserted→asserted (low) during EXEC -> all outputs 0 asynchronously; after release, start sweeps from idx 0 and skips the EXECUTING slot.
